// File: rtl/log2_fraction.sv
// Fractional log2 stage: {integer, fraction} from a normalized mantissa by iterative squaring.
// Optional zero flag (zero_o) when LOG2_ZERO_DETECT_EN is defined.
module log2_fraction #(
    parameter  int WIDTH  = 16,
    parameter  int FRAC_W = 8,
    localparam int NORM_W = $clog2(WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [NORM_W-1:0]        norm_i,
    input  logic                     valid_i,
    output logic [NORM_W+FRAC_W-1:0] log2_o,
    output logic                     valid_o
`ifdef LOG2_ZERO_DETECT_EN
    ,
    output logic                     zero_o
`endif
);

    genvar gi;
    for (gi = 0; gi < FRAC_W; gi++) begin : g_stage
        logic [WIDTH-1:0]   x_in;
        logic [2*WIDTH-1:0] x_ext;
        logic [NORM_W-1:0]  int_in, int_q;
        logic [FRAC_W-1:0]  frac_in, frac_d, frac_q;
        logic               valid_in, valid_q, top_bit;
`ifdef LOG2_ZERO_DETECT_EN
        logic               zero_in, zero_q;
`endif

        if (gi == 0) begin : g_head
            assign x_in     = data_i;
            assign int_in   = NORM_W'(WIDTH - 1) - norm_i;
            assign frac_in  = '0;
            assign valid_in = valid_i;
`ifdef LOG2_ZERO_DETECT_EN
            assign zero_in  = ~data_i[WIDTH-1];
`endif
        end else begin : g_body
            assign x_in     = g_stage[gi-1].g_sq.x_q;
            assign int_in   = g_stage[gi-1].int_q;
            assign frac_in  = g_stage[gi-1].frac_q;
            assign valid_in = g_stage[gi-1].valid_q;
`ifdef LOG2_ZERO_DETECT_EN
            assign zero_in  = g_stage[gi-1].zero_q;
`endif
        end

        assign x_ext = {{WIDTH{1'b0}}, x_in};

        // Square >= 2 sets this fraction bit and the mantissa is renormalized by one more shift.
        if (gi < FRAC_W - 1) begin : g_sq
            logic [WIDTH:0]   sqr_hi;
            logic [WIDTH-1:0] x_d, x_q;

            assign sqr_hi  = (WIDTH+1)'((x_ext * x_ext) >> (WIDTH - 1));
            assign top_bit = sqr_hi[WIDTH];
            assign x_d     = sqr_hi[WIDTH] ? sqr_hi[WIDTH:1] : sqr_hi[WIDTH-1:0];

            always_ff @(posedge clock) begin
                if (reset) begin
                    x_q <= '0;
                end else begin
                    x_q <= x_d;
                end
            end
        end else begin : g_last
            assign top_bit = 1'((x_ext * x_ext) >> (2*WIDTH - 1));
        end

        assign frac_d = frac_in | (FRAC_W'(top_bit) << (FRAC_W - 1 - gi));

        always_ff @(posedge clock) begin
            if (reset) begin
                int_q   <= '0;
                frac_q  <= '0;
                valid_q <= 1'b0;
`ifdef LOG2_ZERO_DETECT_EN
                zero_q  <= 1'b0;
`endif
            end else begin
                int_q   <= int_in;
                frac_q  <= frac_d;
                valid_q <= valid_in;
`ifdef LOG2_ZERO_DETECT_EN
                zero_q  <= zero_in;
`endif
            end
        end
    end

    assign valid_o = g_stage[FRAC_W-1].valid_q;
`ifdef LOG2_ZERO_DETECT_EN
    assign zero_o  = g_stage[FRAC_W-1].zero_q;
    assign log2_o  = g_stage[FRAC_W-1].zero_q ? '0
                   : {g_stage[FRAC_W-1].int_q, g_stage[FRAC_W-1].frac_q};
`else
    assign log2_o  = {g_stage[FRAC_W-1].int_q, g_stage[FRAC_W-1].frac_q};
`endif

endmodule
